irom_loader: RTL and testbench
==============================

# irom_loader

Boot-time program loader that fills the instruction ROM the pipelined core fetches from. It accepts a framed byte stream (from a UART receiver or debug bridge) over a valid/ready handshake and assembles little-endian 32-bit words. It writes them to the IROM write port at consecutive word addresses. It holds the core in reset until the whole program has been written, then releases it.

## Interface
- `ADDR_W`, 14: IROM word-address width. Matches the core's `pc` fetch port; depth is 2^ADDR_W words.
- `TIMEOUT_CYCLES`, 1000000: maximum idle cycles allowed between bytes inside a frame.
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: byte-stream data valid.
- `rx_data` in 8: byte-stream data.
- `rx_ready` out 1: loader can accept a byte. A transfer occurs when `rx_valid && rx_ready` at the clock edge.
- `err_clr` in 1: clears the error state.
- `irom_we` out 1: IROM write enable, one-cycle pulse per word.
- `irom_addr` out ADDR_W: IROM word address.
- `irom_wdata` out 32: IROM write data.
- `cpu_rst_n` out 1: active-low reset to the core; low while loading or in error.
- `busy` out 1: frame in progress.
- `done` out 1: program loaded and core running.
- `err` out 1: frame aborted.

## Operation
- Frame format:
  - 2-byte word count N, little-endian: first byte is N[7:0].
  - Followed by 4·N data bytes.
  - Each word's bytes arrive LSB first: byte k goes to wdata[8k+7:8k].
- FSM states:
  - **HDR0** (reset state): `rx_ready`=1. Accepted byte → N[7:0], go to HDR1.
  - **HDR1**: `rx_ready`=1. Accepted byte → N[15:8], then check the count:
    - N==0 or N>2^ADDR_W → ERR.
    - Otherwise → DATA, with word_idx=0 and byte_idx=0.
  - **DATA**: `rx_ready`=1.
    - Each accepted byte goes into assembly register lane byte_idx; byte_idx increments modulo 4.
    - On the 4th byte, the assembled word is registered onto `irom_wdata`/`irom_addr`=word_idx, `irom_we` pulses, and word_idx increments.
    - After the write of word N-1 → RUN.
  - **RUN**: `rx_ready`=1, `done`=1, `cpu_rst_n`=1. An accepted byte starts a reload: it is taken as N[7:0], state goes to HDR1, and `cpu_rst_n` drops.
  - **ERR**: `rx_ready`=0, `err`=1, `cpu_rst_n`=0. `err_clr`=1 → HDR0. `err_clr` is ignored in all other states.
- Timeout:
  - An idle counter runs only in HDR1 and DATA and clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES → ERR.
  - If a byte is accepted in the same cycle the counter would expire, the byte wins and the counter clears.
- `busy` = (state is HDR1 or DATA).
- IROM contents are never cleared by the loader: partial loads and reset leave already-written words intact.
- Words are written only through complete 4-byte groups. Bytes received after an abort are not written.

## Timing
- Reset values:
  - `rx_ready`=1 (in HDR0).
  - `irom_we`=0, `irom_addr`=0, `irom_wdata`=0.
  - `cpu_rst_n`=0, `busy`=0, `done`=0, `err`=0.
- Throughput: one byte per cycle sustained; `rx_ready` never deasserts during a frame.
- Write latency:
  - The 4th byte of a word accepted at edge T → `irom_we`=1 during cycle T+1, with address and data stable in that cycle.
  - `irom_we` is exactly one cycle wide.
- Release timing:
  - The last data byte accepted at edge T → last write in cycle T+1.
  - State is RUN and `done`=1 from cycle T+1.
  - `cpu_rst_n` rises in cycle T+2, so the core never fetches before the final write completes.
- Reload from RUN:
  - A byte accepted at edge T → `cpu_rst_n`=0 and `done`=0 from cycle T+1.
- Error timing:
  - A bad header byte accepted at edge T → `err`=1 from cycle T+1.
  - Timeout → `err` goes high in the cycle after the counter reaches TIMEOUT_CYCLES.
- Asynchronous reset at any point (including mid-DATA):
  - All outputs return to their reset values immediately; state returns to HDR0.
  - A pending `irom_we` is dropped.

## Test plan
- Two-word load: send bytes 02 00, then 13 05 10 00, then 6F 00 00 00 back-to-back → `irom_we` pulses with addr 0/0x00100513, then addr 1/0x0000006F. `cpu_rst_n` rises 2 cycles after the last byte; `done`=1.
- Zero count: send bytes 00 00 → `err`=1 and no `irom_we` pulse. Pulse `err_clr` → back to HDR0 with `rx_ready`=1; a valid frame then loads correctly.
- Oversize count: with ADDR_W=14, send bytes 01 40 (N=0x4001) → ERR. A frame with N=0x4000 is accepted and writes its last word at addr 0x3FFF.
- Timeout (TIMEOUT_CYCLES=16): send the header for N=1 and 3 data bytes, then idle → `err`=1 after 16 idle cycles. Repeating with the 4th byte delivered after 15 idle cycles → normal write, no error.
- Reload while running: after a completed load, send a new header byte → `cpu_rst_n`=0 the next cycle. The new program overwrites from addr 0, and the core is released again.
- Reset mid-frame: assert `rst_n`=0 after 6 data bytes → all outputs return to their reset values immediately and no write occurs for the partial word. A fresh frame after reset loads correctly.

Source files
------------

// File: rtl/irom_loader.sv
// Boot loader: framed byte stream -> little-endian IROM words.
// Holds the core in reset until the whole program is written.
module irom_loader #(
   parameter int unsigned ADDR_W         = 14,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   input  logic              err_clr,
   output logic              irom_we,
   output logic [ADDR_W-1:0] irom_addr,
   output logic [31:0]       irom_wdata,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned   TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [32:0]   MAX_N     = 33'd1 << ADDR_W;

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_RUN,
      S_ERR
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          nlo_q, nlo_d;
   logic [15:0]         rem_q, rem_d;
   logic [ADDR_W-1:0]   widx_q, widx_d;
   logic [1:0]          bidx_q, bidx_d;
   logic [23:0]         asm_q, asm_d;
   logic [TW-1:0]       idle_q, idle_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                crst_q, crst_d;

   logic                acc;
   logic [15:0]         n_full;
   logic                hdr_bad;
   logic                in_frame;
   logic                expire;
   logic                word_done;

   assign acc       = rx_valid && rx_ready;
   assign n_full    = {rx_data, nlo_q};
   assign hdr_bad   = (n_full == 16'd0) || ({17'd0, n_full} > MAX_N);
   assign in_frame  = (state_q == S_HDR1) || (state_q == S_DATA);
   // an accepted byte always beats an expiring idle counter
   assign expire    = in_frame && !acc && (idle_q == IDLE_LAST);
   assign word_done = acc && (state_q == S_DATA) && (bidx_q == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_HDR0;
         nlo_q   <= '0;
         rem_q   <= '0;
         widx_q  <= '0;
         bidx_q  <= '0;
         asm_q   <= '0;
         idle_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         crst_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         nlo_q   <= nlo_d;
         rem_q   <= rem_d;
         widx_q  <= widx_d;
         bidx_q  <= bidx_d;
         asm_q   <= asm_d;
         idle_q  <= idle_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         crst_q  <= crst_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_HDR0: begin
            if (acc) state_d = S_HDR1;
         end
         S_HDR1: begin
            if (acc)         state_d = hdr_bad ? S_ERR : S_DATA;
            else if (expire) state_d = S_ERR;
         end
         S_DATA: begin
            if (word_done && (rem_q == 16'd0)) state_d = S_RUN;
            else if (expire)                   state_d = S_ERR;
         end
         S_RUN: begin
            if (acc) state_d = S_HDR1;
         end
         S_ERR: begin
            if (err_clr) state_d = S_HDR0;
         end
         default: state_d = S_HDR0;
      endcase
   end

   always_comb begin
      nlo_d   = nlo_q;
      rem_d   = rem_q;
      widx_d  = widx_q;
      bidx_d  = bidx_q;
      asm_d   = asm_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      idle_d  = '0;

      if (in_frame && !acc && !expire) idle_d = idle_q + 1'b1;

      if (acc && ((state_q == S_HDR0) || (state_q == S_RUN))) begin
         nlo_d = rx_data;
      end

      if (acc && (state_q == S_HDR1)) begin
         rem_d  = n_full - 16'd1;
         widx_d = '0;
         bidx_d = '0;
      end

      if (acc && (state_q == S_DATA)) begin
         bidx_d = bidx_q + 2'd1;
         unique case (bidx_q)
            2'd0: asm_d[7:0]   = rx_data;
            2'd1: asm_d[15:8]  = rx_data;
            2'd2: asm_d[23:16] = rx_data;
            2'd3: begin
               we_d    = 1'b1;
               addr_d  = widx_q;
               wdata_d = {rx_data, asm_q};
               widx_d  = widx_q + 1'b1;
               rem_d   = rem_q - 16'd1;
            end
            default: ;
         endcase
      end

      // release lags RUN by one cycle so the last write lands first
      crst_d = (state_q == S_RUN) && !acc;
   end

   always_comb begin
      rx_ready   = (state_q != S_ERR);
      busy       = in_frame;
      done       = (state_q == S_RUN);
      err        = (state_q == S_ERR);
      irom_we    = we_q;
      irom_addr  = addr_q;
      irom_wdata = wdata_q;
      cpu_rst_n  = crst_q;
   end

endmodule

// File: tb/tb_irom_loader.sv
// Scoreboard bench for irom_loader: random frames vs. a word-level
// model of which IROM writes each byte stream must produce.
module tb_irom_loader;

   localparam int unsigned AW = 10;
   localparam int unsigned TO = 16;

   logic          clk;
   logic          rst_n;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic          err_clr;
   logic          irom_we;
   logic [AW-1:0] irom_addr;
   logic [31:0]   irom_wdata;
   logic          cpu_rst_n;
   logic          busy;
   logic          done;
   logic          err;

   irom_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .err_clr    (err_clr),
      .irom_we    (irom_we),
      .irom_addr  (irom_addr),
      .irom_wdata (irom_wdata),
      .cpu_rst_n  (cpu_rst_n),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] words[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          last_addr = -1;
   logic        prev_we = 1'b0;
   wr_t         mon_e;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      prev_we <= irom_we;
      if (rst_n && irom_we) begin
         chk("we_one_cycle", 32'(prev_we), 32'd0);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                     irom_addr, irom_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("waddr", 32'(irom_addr), 32'(mon_e.a));
            chk("wdata", irom_wdata, mon_e.d);
            last_addr <= int'(irom_addr);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) tick();
      chk("rx_ready", 32'(rx_ready), 32'd1);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic fill(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   // Model: a header 1..2^AW yields one write per complete 4-byte group sent
   task automatic send_frame(input int n, input int nsend, input int gmax,
                             input int last_gap);
      logic [7:0]  bq[$];
      logic [15:0] nn;
      logic [31:0] w;
      wr_t         e;
      int          gap;
      nn = 16'(n);
      bq.push_back(nn[7:0]);
      bq.push_back(nn[15:8]);
      for (int i = 0; i < n && i < words.size(); i++) begin
         w = words[i];
         bq.push_back(w[7:0]);
         bq.push_back(w[15:8]);
         bq.push_back(w[23:16]);
         bq.push_back(w[31:24]);
      end
      if (n >= 1 && n <= (1 << AW)) begin
         for (int i = 0; i < n; i++) begin
            if (2 + 4 * (i + 1) <= nsend) begin
               e.a = AW'(i);
               e.d = words[i];
               exp_q.push_back(e);
            end
         end
      end
      if (nsend > bq.size()) nsend = bq.size();
      for (int k = 0; k < nsend; k++) begin
         gap = (k == nsend - 1) ? last_gap : int'($urandom_range(0, gmax));
         send_byte(bq[k], gap);
         if (k == 0) begin
            chk("hdr_busy", 32'(busy), 32'd1);
            chk("hdr_done", 32'(done), 32'd0);
            chk("hdr_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
         end
      end
   endtask

   task automatic check_release();
      chk("rel_done", 32'(done), 32'd1);
      chk("rel_cpu_rst_n_t1", 32'(cpu_rst_n), 32'd0);
      chk("rel_busy", 32'(busy), 32'd0);
      chk("rel_err", 32'(err), 32'd0);
      tick();
      chk("rel_cpu_rst_n_t2", 32'(cpu_rst_n), 32'd1);
      chk("rel_done_t2", 32'(done), 32'd1);
   endtask

   task automatic check_reset_vals();
      chk("rst_rx_ready", 32'(rx_ready), 32'd1);
      chk("rst_we", 32'(irom_we), 32'd0);
      chk("rst_addr", 32'(irom_addr), 32'd0);
      chk("rst_wdata", irom_wdata, 32'd0);
      chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
   endtask

   task automatic clear_err();
      chk("err_set", 32'(err), 32'd1);
      chk("err_rx_ready", 32'(rx_ready), 32'd0);
      chk("err_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      repeat (3) tick();
      chk("err_sticky", 32'(err), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_cleared", 32'(err), 32'd0);
      chk("clr_rx_ready", 32'(rx_ready), 32'd1);
      chk("clr_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      err_clr  = 1'b0;
      #3;
      check_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_reset_vals();

      // two-word directed load
      words.delete();
      words.push_back(32'h0010_0513);
      words.push_back(32'h0000_006F);
      send_frame(2, 10, 0, 0);
      check_release();

      // zero count
      words.delete();
      send_frame(0, 2, 0, 0);
      clear_err();
      fill(2);
      send_frame(2, 10, 2, 1);
      check_release();

      // oversize count, then largest legal count
      send_frame((1 << AW) + 1, 2, 0, 0);
      clear_err();
      fill(1 << AW);
      send_frame(1 << AW, 2 + 4 * (1 << AW), 0, 0);
      check_release();
      chk("last_addr", 32'(last_addr), 32'((1 << AW) - 1));

      // timeout after 3 of 4 bytes
      fill(1);
      send_frame(1, 5, 0, 0);
      repeat (TO - 1) tick();
      chk("to_not_yet", 32'(err), 32'd0);
      chk("to_busy", 32'(busy), 32'd1);
      tick();
      chk("to_expired", 32'(err), 32'd1);
      clear_err();
      fill(1);
      send_frame(1, 6, 0, TO - 1);
      check_release();

      // random frames, each a reload from RUN
      for (int r = 0; r < 6; r++) begin
         int n;
         n = int'($urandom_range(1, 8));
         fill(n);
         send_frame(n, 2 + 4 * n, 3, int'($urandom_range(0, 3)));
         check_release();
      end

      // reset in the middle of word 1
      fill(3);
      send_frame(3, 8, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      fill(2);
      send_frame(2, 10, 1, 0);
      check_release();

      repeat (3) tick();
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      n_bad++;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

endmodule
